// File: rtl/lcd_win_ctrl.sv
// Windowed LCD controller: buffers an IMG_W x IMG_H image and streams a WIN x WIN window
// (strided zoom-fit or panned zoom-in). Optional column mirroring under LCD_WIN_MIRROR_EN.
module lcd_win_ctrl #(
  parameter int DW     = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_X0 = 1,
  parameter int FIT_Y0 = 1,
  parameter int FIT_SX = 3,
  parameter int FIT_SY = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2:0]                 cmd,
  input  logic                       cmd_valid,
  output logic                       busy,
  input  logic [DW-1:0]              datain,
  input  logic                       datain_valid,
  output logic [DW-1:0]              dataout,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic                       mode,
  output logic [$clog2(IMG_W)-1:0]   org_x,
  output logic [$clog2(IMG_H)-1:0]   org_y
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int CW     = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int CX     = (IMG_W - WIN + 1) / 2;
  localparam int CY     = (IMG_H - WIN + 1) / 2;

  if (WIN > IMG_W || WIN > IMG_H) begin : g_bad_win
    $error("lcd_win_ctrl: WIN larger than image");
  end
  if (FIT_X0 + (WIN-1)*FIT_SX >= IMG_W || FIT_Y0 + (WIN-1)*FIT_SY >= IMG_H) begin : g_bad_fit
    $error("lcd_win_ctrl: fit sampling grid exceeds image");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DISP} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]     mem [NPIX];
  logic [ADDR_W-1:0] cnt;
  logic [2:0]        cmd_q;
  logic [CW-1:0]     r_cnt, c_cnt, c_eff;
  logic [ADDR_W-1:0] row_a, col_a, rd_addr;
  logic              cmd_ok, accept, last_pix, load_last, mirror;

`ifdef LCD_WIN_MIRROR_EN
  assign cmd_ok = 1'b1;
`else
  assign cmd_ok = (cmd != 3'd7);
  assign mirror = 1'b0;
`endif

  assign accept    = cmd_valid && (state == S_IDLE) && cmd_ok;
  assign last_pix  = (r_cnt == CW'(WIN-1)) && (c_cnt == CW'(WIN-1));
  assign load_last = (cnt == ADDR_W'(NPIX-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != S_IDLE);
    output_valid = (state == S_DISP);
    case (state)
      S_IDLE: if (accept) state_nxt = (cmd == 3'd0) ? S_LOAD : S_CALC;
      S_LOAD: if (datain_valid && load_last) state_nxt = S_CALC;
      S_CALC: state_nxt = S_DISP;
      S_DISP: if (output_ready && last_pix) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pixel buffer: written only during LOAD, never reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && datain_valid) mem[cnt] <= datain;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= 3'd0;
      cnt   <= '0;
      r_cnt <= '0;
      c_cnt <= '0;
      mode  <= 1'b0;
      org_x <= XW'(CX);
      org_y <= YW'(CY);
    end else begin
      case (state)
        S_IDLE: if (accept) cmd_q <= cmd;
        S_LOAD: if (datain_valid) begin
          if (load_last) begin
            cnt   <= '0;
            mode  <= 1'b0;
            org_x <= XW'(CX);
            org_y <= YW'(CY);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CALC: begin
          r_cnt <= '0;
          c_cnt <= '0;
          case (cmd_q)
            3'd1: begin
              if (!mode) begin
                org_x <= XW'(CX);
                org_y <= YW'(CY);
              end
              mode <= 1'b1;
            end
            3'd2: begin
              mode  <= 1'b0;
              org_x <= XW'(CX);
              org_y <= YW'(CY);
            end
            3'd3: if (mode && org_x < XW'(IMG_W-WIN)) org_x <= org_x + 1'b1;
            3'd4: if (mode && org_x != '0) org_x <= org_x - 1'b1;
            3'd5: if (mode && org_y != '0) org_y <= org_y - 1'b1;
            3'd6: if (mode && org_y < YW'(IMG_H-WIN)) org_y <= org_y + 1'b1;
            default: ;
          endcase
        end
        S_DISP: if (output_ready) begin
          if (c_cnt == CW'(WIN-1)) begin
            c_cnt <= '0;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LCD_WIN_MIRROR_EN
  // Mirror toggles on cmd 7; cleared by load completion and zoom-fit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mirror <= 1'b0;
    end else if (state == S_LOAD && datain_valid && load_last) begin
      mirror <= 1'b0;
    end else if (state == S_CALC) begin
      if (cmd_q == 3'd2)      mirror <= 1'b0;
      else if (cmd_q == 3'd7) mirror <= ~mirror;
    end
  end
`endif

  // Read address built from separate row/column terms so pans never wrap rows.
  always_comb begin
    c_eff = mirror ? (CW'(WIN-1) - c_cnt) : c_cnt;
    if (mode) begin
      row_a = ADDR_W'(org_y) + ADDR_W'(r_cnt);
      col_a = ADDR_W'(org_x) + ADDR_W'(c_eff);
    end else begin
      row_a = ADDR_W'(FIT_Y0) + ADDR_W'(r_cnt) * ADDR_W'(FIT_SY);
      col_a = ADDR_W'(FIT_X0) + ADDR_W'(c_eff) * ADDR_W'(FIT_SX);
    end
    rd_addr = row_a * ADDR_W'(IMG_W) + col_a;
  end

  assign dataout = output_valid ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl: a window model pushes expected pixels per command,
// a negedge monitor pops and compares each transferred pixel.
module tb_lcd_win_ctrl;
  localparam int DW = 8, IMG_W = 12, IMG_H = 9, WIN = 4;
  localparam int FX0 = 1, FY0 = 1, FSX = 3, FSY = 2;
  localparam int NPIX = IMG_W * IMG_H, CX = 4, CY = 3;
`ifdef LCD_WIN_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic [DW-1:0] datain;
  logic          datain_valid;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          output_ready = 1'b1;
  logic          mode;
  logic [3:0]    org_x;
  logic [3:0]    org_y;

  always #5 clk = ~clk;

  lcd_win_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .datain(datain), .datain_valid(datain_valid), .dataout(dataout),
    .output_valid(output_valid), .output_ready(output_ready), .mode(mode),
    .org_x(org_x), .org_y(org_y)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_xfer = 0, last_xfer_cyc = -10, rmode = 0, hold_n = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] img[NPIX];
  bit m_mode, m_mir;
  int m_ox, m_oy;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Sink handshake: always ready, random, or a scripted stall on pixels 2..4.
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: output_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if ((n_xfer % 16) >= 2 && (n_xfer % 16) <= 4 && hold_n < 2) begin
          output_ready = 1'b0;
          hold_n++;
        end else begin
          output_ready = 1'b1;
          hold_n = 0;
        end
      end
      default: output_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall && output_valid) chk("hold_dataout", dataout, prev_data);
      prev_stall = output_valid && !output_ready;
      prev_data  = dataout;
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pixel: got %0d expected none", dataout);
        end else begin
          chk("pixel", dataout, exp_q.pop_front());
        end
        n_xfer++;
        last_xfer_cyc = cyc;
      end
    end
  end

  function automatic void push_window();
    int x, y, cc;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        cc = m_mir ? (WIN - 1 - c) : c;
        if (m_mode) begin
          x = m_ox + cc;
          y = m_oy + r;
        end else begin
          x = FX0 + cc * FSX;
          y = FY0 + r * FSY;
        end
        exp_q.push_back(img[y * IMG_W + x]);
      end
  endfunction

  function automatic void model_cmd(input int c);
    case (c)
      1: begin
        if (!m_mode) begin m_ox = CX; m_oy = CY; end
        m_mode = 1'b1;
      end
      2: begin m_mode = 1'b0; m_ox = CX; m_oy = CY; m_mir = 1'b0; end
      3: if (m_mode) m_ox = (m_ox + 1 > IMG_W - WIN) ? IMG_W - WIN : m_ox + 1;
      4: if (m_mode) m_ox = (m_ox - 1 < 0) ? 0 : m_ox - 1;
      5: if (m_mode) m_oy = (m_oy - 1 < 0) ? 0 : m_oy - 1;
      6: if (m_mode) m_oy = (m_oy + 1 > IMG_H - WIN) ? IMG_H - WIN : m_oy + 1;
      7: m_mir = !m_mir;
      default: ;
    endcase
    push_window();
  endfunction

  task automatic issue(input int c);
    cmd = 3'(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (busy === 1'b1 && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got busy=%b expected 0", busy);
    end else begin
      chk("busy_fall_cycle", cyc, last_xfer_cyc + 1);
      chk("valid_after_done", output_valid, 0);
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("mode", mode, m_mode);
    chk("org_x", org_x, m_ox);
    chk("org_y", org_y, m_oy);
  endtask

  task automatic run_cmd(input int c);
    if (c != 7 || MIR) begin
      model_cmd(c);
      issue(c);
      chk("busy_after_accept", busy, 1);
      wait_done();
    end else begin
      issue(c);
      chk("busy_illegal", busy, 0);
      @(posedge clk); #1;
      chk("busy_illegal_next", busy, 0);
    end
  endtask

  task automatic do_load(input bit addr_pat);
    int idx = 0, k = 0, t = 0;
    for (int i = 0; i < NPIX; i++) img[i] = addr_pat ? DW'(i) : DW'($urandom);
    issue(0);
    chk("busy_load_start", busy, 1);
    while (idx < NPIX && t < 2000) begin
      datain_valid = addr_pat ? (k % 3 != 2) : ($urandom_range(0, 2) != 0);
      datain = datain_valid ? img[idx] : DW'($urandom);
      @(posedge clk); #1;
      if (datain_valid) idx++;
      k++;
      t++;
      chk("busy_during_load", busy, 1);
    end
    datain_valid = 1'b0;
    m_mode = 1'b0; m_ox = CX; m_oy = CY; m_mir = 1'b0;
    push_window();
    wait_done();
  endtask

  initial begin
    reset_n = 1'b0; cmd = 3'd0; cmd_valid = 1'b0; datain = '0; datain_valid = 1'b0;
    m_mode = 1'b0; m_ox = CX; m_oy = CY; m_mir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", output_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_mode", mode, 0);
    chk("rst_org_x", org_x, CX);
    chk("rst_org_y", org_y, CY);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_load(1'b1);

    // Zoom-in with first-pixel latency check
    model_cmd(1);
    issue(1);
    chk("zoom_busy_k1", busy, 1);
    chk("zoom_valid_k1", output_valid, 0);
    @(posedge clk); #1;
    chk("zoom_valid_k2", output_valid, 1);
    wait_done();

    repeat (5) run_cmd(3);
    repeat (4) run_cmd(5);

    run_cmd(2);
    rmode = 2;
    run_cmd(1);
    rmode = 0;

    // Command pulsed mid-display must be dropped
    model_cmd(2);
    issue(2);
    repeat (6) begin @(posedge clk); #1; end
    cmd = 3'd1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();
    run_cmd(3);

`ifdef LCD_WIN_MIRROR_EN
    run_cmd(1);
    run_cmd(7);
    run_cmd(2);
`else
    run_cmd(7);
`endif

    rmode = 1;
    do_load(1'b0);
    repeat (25) run_cmd($urandom_range(1, 7));
    rmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_win_ctrl.md
Name: lcd_win_ctrl

Overview:
- Parametrised successor to the team's fixed 12x9 LCD controller.
- Loads an IMG_W x IMG_H image into an internal buffer and streams a WIN x WIN window to the LCD datapath.
- Two modes: zoom-fit (strided subsample) and zoom-in (contiguous window, panned by shift commands).
- New versus the previous generation: generic geometry and pixel width, load qualified by datain_valid, output backpressure via output_ready, and observable mode/origin outputs.

Parameters:
- DW, 8, pixel width in bits.
- IMG_W, 12, image width in pixels.
- IMG_H, 9, image height in pixels.
- WIN, 4, output window edge; window is WIN x WIN pixels.
- FIT_X0, 1, first column sampled in fit mode.
- FIT_Y0, 1, first row sampled in fit mode.
- FIT_SX, 3, column stride in fit mode.
- FIT_SY, 2, row stride in fit mode.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- cmd  in  3  0 load, 1 zoom-in, 2 zoom-fit, 3 right, 4 left, 5 up, 6 down, 7 reserved.
- cmd_valid  in  1  command strobe.
- busy  out  1  high while a command is in progress.
- datain  in  DW  load pixel, raster order.
- datain_valid  in  1  datain qualifier, honoured only in LOAD.
- dataout  out  DW  window pixel.
- output_valid  out  1  dataout valid.
- output_ready  in  1  sink accepts dataout.
- mode  out  1  0 fit, 1 zoom-in.
- org_x  out  clog2(IMG_W)  zoom-in window column origin.
- org_y  out  clog2(IMG_H)  zoom-in window row origin.

Behaviour:
- Reset values: busy=0, output_valid=0, dataout=0, mode=0, org_x=CX, org_y=CY.
  - CX=(IMG_W-WIN+1)/2 and CY=(IMG_H-WIN+1)/2, integer division; defaults give 4,3, i.e. address 40.
  - Buffer contents are not cleared by reset.
- Address rule: addr = y*IMG_W + x; ADDR_W = clog2(IMG_W*IMG_H). Origin arithmetic is done on separate x/y counters, never on the flat address, so no row wrap is possible.
- Elaboration must fail if WIN>IMG_W, WIN>IMG_H, FIT_X0+(WIN-1)*FIT_SX>=IMG_W, or FIT_Y0+(WIN-1)*FIT_SY>=IMG_H.
- Command acceptance:
  - A command is accepted at an edge where cmd_valid=1, busy=0, and cmd is legal. cmd is sampled at that edge.
  - cmd_valid while busy=1 is ignored, not queued.
  - Illegal cmd is ignored; busy stays 0.
- States:
  - IDLE: wait for an accepted command. load -> LOAD; any other accepted command -> CALC. busy=1 from the next cycle.
  - LOAD: writes datain to buffer[cnt] and increments cnt on each cycle with datain_valid=1. Cycles without datain_valid stall the load. After write IMG_W*IMG_H-1: cnt clears, mode=0, origin=(CX,CY), -> CALC.
  - CALC: one cycle. Applies the command:
    - zoom-in: mode=1; origin kept if already in zoom-in, else set to (CX,CY).
    - zoom-fit: mode=0, origin=(CX,CY).
    - shift in zoom-in: right x+1 saturating at IMG_W-WIN; left x-1 saturating at 0; up y-1 saturating at 0; down y+1 saturating at IMG_H-WIN.
    - shift in fit mode: no state change; the fit window is redisplayed.
    - Then -> DISP with pixel index i=0.
  - DISP: emits WIN*WIN pixels in raster order, r=i/WIN, c=i%WIN.
    - Fit pixel: buffer[(FIT_Y0+r*FIT_SY)*IMG_W + FIT_X0+c*FIT_SX].
    - Zoom-in pixel: buffer[(org_y+r)*IMG_W + org_x+c].
    - A pixel transfers on an edge with output_valid && output_ready. dataout and output_valid hold stable while output_ready=0.
    - After the last transfer: output_valid=0 and busy=0 on the next cycle -> IDLE.
- Latency: command accepted at edge k; busy=1 from k+1; first output_valid at k+2. Minimum of WIN*WIN+2 cycles from accept to busy falling when output_ready is held high.
- Mid-operation: reset_n low at any point forces all reset values immediately. No command can pre-empt LOAD or DISP.

Optional Feature:
- Macro: LCD_WIN_MIRROR_EN.
- Defined:
  - cmd 7 is legal; in CALC it toggles a mirror flag, then the current window is redisplayed.
  - With mirror set, column index c is replaced by WIN-1-c in both modes.
  - The mirror flag clears on reset, load, and zoom-fit.
- Undefined: cmd 7 is illegal and ignored, and no mirror logic is built.

Test Plan:
- Reset, then load 108 pixels with value=address and datain_valid gapped every 3rd cycle -> busy high throughout; output 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94; busy falls one cycle after the last pixel; mode=0.
- Zoom-in after load -> 40..43, 52..55, 64..67, 76..79; org=(4,3); first output_valid two cycles after accept.
- Five rights then four ups in zoom-in -> org_x saturates at 8 after 4 rights; 5th right redisplays starting at pixel 44. org_y saturates at 0 after 3 ups; 4th up redisplays starting at pixel 8.
- output_ready low for the 3rd through 5th pixels of a zoom-in display -> dataout holds at 42 while output_ready is low; all 16 pixels are delivered once each, in order.
- cmd_valid pulsed during DISP, then shift right issued in fit mode -> mid-display command ignored; shift in fit mode re-emits the fit sequence with org unchanged.
- With LCD_WIN_MIRROR_EN, zoom-in then cmd 7 -> 43,42,41,40,55,...; zoom-fit afterwards -> unmirrored 13,16,...
